gpio_bank: RTL
==============

# gpio_bank

Parametrised multi-port GPIO peripheral for the multicycle processor, replacing the single fixed 8-bit output register and raw 8-bit input path. It provides PORTS independent ports of WIDTH bits, each with an output register, a synchronised input, sticky change flags and an interrupt mask. All of these are accessed through a word-addressed register interface driven by the datapath's address/write-data/write-enable signals. A combined `irq` line goes to the control unit.

## Interface
- `WIDTH`, 8: bits per port, 1..32
- `PORTS`, 2: number of ports, power of two, 1..8
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4
- `ADDR_W`, 4: register address width, must be ≥ clog2(PORTS)+2
- `clk`  in  1: single clock, all logic on rising edge
- `reset`  in  1: synchronous, active-low reset
- `wr_en`  in  1: register write strobe
- `rd_en`  in  1: register read strobe
- `addr`  in  ADDR_W: register address = {port index, reg[1:0]}
- `wdata`  in  32: write data; bits [WIDTH-1:0] used
- `rdata`  out  32: read data, zero-extended from WIDTH
- `rvalid`  out  1: rdata valid, one-cycle pulse
- `gpio_i`  in  PORTS*WIDTH: external inputs, port p at [p*WIDTH +: WIDTH], asynchronous
- `gpio_o`  out  PORTS*WIDTH: output registers, same packing
- `irq`  out  1: OR over all ports of (EDGE & MASK), registered

## Operation
- Register map per port (reg field of addr):
  - 0 = OUT (rw)
  - 1 = IN (ro; synchronised input)
  - 2 = EDGE (sticky change flags; write-1-to-clear)
  - 3 = MASK (rw)
- Port index = addr[ADDR_W-1:2]. An index ≥ PORTS selects nothing: writes are ignored, reads return 0 with rvalid.
- Writes to IN have no effect.
- Synchroniser: each gpio_i bit passes through a SYNC_STAGES flop chain. The final stage is IN.
- Change detect: PREV register holds IN of the previous cycle. While armed, each bit where IN ≠ PREV sets the matching EDGE bit.
- Arming: after reset deasserts, a counter runs SYNC_STAGES+1 cycles. Edge detection is disabled until it saturates, which suppresses spurious flags from the chain filling. After that the block stays armed until the next reset.
- EDGE write: bits with wdata=1 are cleared. A set and a clear on the same bit in the same cycle resolve to set.
- Reads: sampled when rd_en=1.
  - Reading EDGE does not clear it.
  - rd_en and wr_en in the same cycle to the same register: write applies, read returns the pre-write value.
- Reset (reset=0 at a clock edge), regardless of any operation in progress, clears:
  - OUT, MASK, EDGE, PREV, the sync chain and the arm counter
  - rdata=0, rvalid=0, irq=0, gpio_o=0
- Bus accesses during reset are ignored.

## Timing
- Write latency: gpio_o (OUT), MASK or EDGE change at the clock edge where wr_en=1. New values are visible the following cycle.
- Read latency: 1 cycle. rdata and rvalid register on the rd_en edge. rvalid is high for exactly one cycle per rd_en cycle, and back-to-back reads give back-to-back rvalid. rdata holds its last value when rvalid=0.
- Input latency: a gpio_i change is visible in IN SYNC_STAGES edges later. The EDGE bit sets on the next edge, and irq asserts on the edge after that (SYNC_STAGES+2 total when masked).
- irq: deasserts one cycle after the last contributing EDGE bit is cleared or masked off.
- Arm counter: armed from cycle SYNC_STAGES+1 after the first edge with reset=1.

## Test plan
All scenarios use defaults (WIDTH=8, PORTS=2, SYNC_STAGES=2, ADDR_W=4).
- Reset then idle with gpio_i=16'hFFFF -> EDGE of both ports stays 0, irq=0; read addr 1 returns 0x000000FF, rvalid one cycle after rd_en.
- Write OUT port1 (addr 4'h4) = 32'h1234_56A5 -> gpio_o=16'hA500 next cycle; read addr 4 returns 0x000000A5.
- Set MASK port0=8'h01, then toggle gpio_i[0] 0→1 -> EDGE0=8'h01 at cycle +3, irq=1 at cycle +4; write EDGE0=8'h01 -> irq=0 one cycle later.
- Write-1-to-clear EDGE bit 0 in the same cycle a new change sets it -> EDGE0 bit 0 stays 1, irq stays 1.
- Read and write OUT port0 in the same cycle (old 8'h00, new 8'h3C) -> rdata=0, then a subsequent read returns 0x3C; read addr 4'h8 (port 2, absent) -> rdata=0, rvalid=1.
- Assert reset mid-operation with OUT=8'hFF, EDGE=8'h0F, irq=1 -> all outputs 0 next edge; no EDGE set for SYNC_STAGES+1 cycles after release even with gpio_i changing.

Source files
------------

// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bank
// Description : Multi-port GPIO peripheral. Each of PORTS ports has an output
//               register, a synchronised input, sticky change flags (EDGE,
//               write-1-to-clear) and an interrupt mask, all reached through a
//               word-addressed register interface. irq is the registered OR of
//               EDGE & MASK over every port.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int PORTS       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     rvalid,
    input  logic [PORTS*WIDTH-1:0]   gpio_i,
    output logic [PORTS*WIDTH-1:0]   gpio_o,
    output logic                     irq
);

    localparam int         c_pw        = PORTS * WIDTH;
    localparam int         c_iw        = ADDR_W - 2;
    // Detection stays off until the sync chain has filled and PREV holds a
    // real sample, so the reset-to-input transition never raises a flag.
    localparam logic [2:0] c_arm_limit = 3'(SYNC_STAGES + 1);

    localparam logic [1:0] c_reg_out  = 2'd0;
    localparam logic [1:0] c_reg_in   = 2'd1;
    localparam logic [1:0] c_reg_edge = 2'd2;
    localparam logic [1:0] c_reg_mask = 2'd3;

    // Registered state
    logic [c_pw-1:0] out_q,       out_d;
    logic [c_pw-1:0] mask_q,      mask_d;
    logic [c_pw-1:0] edge_flag_q, edge_flag_d;
    logic [c_pw-1:0] prev_q,      prev_d;
    logic [c_pw-1:0] sync_q [SYNC_STAGES];
    logic [c_pw-1:0] sync_d [SYNC_STAGES];
    logic [2:0]      arm_q,       arm_d;
    logic            irq_q,       irq_d;
    logic [31:0]     rdata_q,     rdata_d;
    logic            rvalid_q,    rvalid_d;

    // Combinational helpers
    logic [c_iw-1:0]  w_idx;
    logic [1:0]       w_reg;
    logic [PORTS-1:0] w_sel;
    logic [c_pw-1:0]  w_in;
    logic [c_pw-1:0]  w_set;
    logic [c_pw-1:0]  w_clr;
    logic             w_armed;
    logic [WIDTH-1:0] w_rd_val;

    assign w_idx   = addr[ADDR_W-1:2];
    assign w_reg   = addr[1:0];
    assign w_in    = sync_q[SYNC_STAGES-1];
    assign w_armed = (arm_q == c_arm_limit);

    // Port select: an index at or beyond PORTS matches no port at all.
    generate
        for (genvar p = 0; p < PORTS; p++) begin : g_port
            localparam logic [c_iw-1:0] c_idx = c_iw'(p);
            assign w_sel[p] = (w_idx == c_idx);
        end
    endgenerate

    // Only the low WIDTH bits of the write bus carry data.
    generate
        if (WIDTH < 32) begin : g_wdata_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^wdata[31:WIDTH];
        end
    endgenerate

    // Input synchroniser chain and previous-sample register
    always_comb begin
        sync_d[0] = gpio_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = w_in;
    end

    // Arm counter saturates at c_arm_limit and stays there until reset
    always_comb begin
        arm_d = (arm_q == c_arm_limit) ? arm_q : arm_q + 3'd1;
    end

    // Register write decode: OUT and MASK load, EDGE collects clear bits
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        w_clr  = '0;
        if (wr_en) begin
            for (int p = 0; p < PORTS; p++) begin
                if (w_sel[p]) begin
                    case (w_reg)
                        c_reg_out:  out_d[p*WIDTH +: WIDTH]  = wdata[WIDTH-1:0];
                        c_reg_edge: w_clr[p*WIDTH +: WIDTH]  = wdata[WIDTH-1:0];
                        c_reg_mask: mask_d[p*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
                        default:    ;
                    endcase
                end
            end
        end
    end

    // Sticky change flags; a new change outranks a simultaneous clear
    always_comb begin
        w_set       = w_armed ? (w_in ^ prev_q) : '0;
        edge_flag_d = (edge_flag_q & ~w_clr) | w_set;
        irq_d       = |(edge_flag_q & mask_q);
    end

    // Read mux works on pre-write state so a same-cycle write is not seen
    always_comb begin
        w_rd_val = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (w_sel[p]) begin
                case (w_reg)
                    c_reg_out:  w_rd_val = out_q[p*WIDTH +: WIDTH];
                    c_reg_in:   w_rd_val = w_in[p*WIDTH +: WIDTH];
                    c_reg_edge: w_rd_val = edge_flag_q[p*WIDTH +: WIDTH];
                    default:    w_rd_val = mask_q[p*WIDTH +: WIDTH];
                endcase
            end
        end
        rdata_d  = rd_en ? 32'(w_rd_val) : rdata_q;
        rvalid_d = rd_en;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            out_q       <= '0;
            mask_q      <= '0;
            edge_flag_q <= '0;
            prev_q      <= '0;
            arm_q       <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            out_q       <= out_d;
            mask_q      <= mask_d;
            edge_flag_q <= edge_flag_d;
            prev_q      <= prev_d;
            arm_q       <= arm_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign gpio_o = out_q;
    assign irq    = irq_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
`default_nettype wire
